lsu_rf_writer: RTL

- Memory-access and write-back sequencer for the single-cycle RISC-V core; it is the writer side of the register-file write port.
- Accepts one decoded load/store at a time, performs the data-memory transaction over a valid/ready request channel and a valid response channel, and aligns and extends load data.
- Drives w_en, rd_id and rd_write_data into the register file.
- Stalls the core through busy_o while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 41 ++++
 rtl/lsu_rf_writer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcode and funct3 encodings,
// the sequencer state type, and small decode helpers used by the LSU and
// its load-alignment datapath.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RSP   = 3'd2,
    WB    = 3'd3,
    ABORT = 3'd4
  } lsu_state_t;

  function automatic logic is_load(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_LOAD) && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  function automatic logic is_store(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_STORE) && (f3 inside {F3_B, F3_H, F3_W});
  endfunction

  // funct3[1:0] encodes access size for both loads and stores: 00 byte,
  // 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension.
// Purely combinational: selects the byte/half/word addressed by byte_off_i
// from the read word and sign- or zero-extends it according to funct3_i.
//   rdata_i    : 32-bit word returned by memory
//   byte_off_i : addr[1:0] of the load
//   funct3_i   : load funct3 (lb/lh/lw/lbu/lhu)
//   data_o     : 32-bit value to write back
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0 before extending.
  assign shifted = rdata_i >> {byte_off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = ext_byte(shifted[7:0], 1'b1);
      F3_BU:   data_o = ext_byte(shifted[7:0], 1'b0);
      F3_H:    data_o = ext_half(shifted[15:0], 1'b1);
      F3_HU:   data_o = ext_half(shifted[15:0], 1'b0);
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_rf_writer.sv
// Memory-access and write-back sequencer for the single-cycle core.
// Takes one decoded load/store at a time, runs the data-memory transaction
// over a valid/ready request channel plus a valid response channel, aligns
// and extends load data, and drives the register-file write port.
//   clk, rst                 : clock, synchronous active-high reset
//   start_i, instr_i, addr_i,
//   store_data_i             : operation from execute (sampled in IDLE)
//   busy_o                   : stall the core while not IDLE
//   done_o, misalign_o,
//   bus_err_o                : one-cycle completion / abort pulses
//   mem_req_*                : request channel (valid/ready)
//   mem_rsp_*                : response channel (valid only)
//   rf_w_en_o, rf_rd_id_o,
//   rf_rd_data_o             : register-file write port
module lsu_rf_writer
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            misalign_o,
  output logic            bus_err_o,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic            mem_req_we_o,
  output logic [3:0]      mem_req_wstrb_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  output logic            rf_w_en_o,
  output logic [4:0]      rf_rd_id_o,
  output logic [XLEN-1:0] rf_rd_data_o
);

  localparam int CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       f3_q, f3_d;
  logic [4:0]       rd_q, rd_d;
  logic             st_q, st_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      sdata_q, sdata_d;
  logic [31:0]      ldata_q, ldata_d;

  logic [6:0]       opc_in;
  logic [2:0]       f3_in;
  logic             ld_ok, st_ok;
  logic [31:0]      aligned;
  logic [3:0]       strb;
  logic [31:0]      wdata;
  logic             in_req, in_wb;
  logic             done, misalign, bus_err, w_en;

  // Upper instruction bits (rs1/rs2/imm) are resolved upstream.
  logic unused_instr;
  assign unused_instr = ^instr_i[31:15];

  assign opc_in = instr_i[6:0];
  assign f3_in  = instr_i[14:12];
  assign ld_ok  = is_load(opc_in, f3_in);
  assign st_ok  = is_store(opc_in, f3_in);

  lsu_load_align u_align (
    .rdata_i    (mem_rsp_rdata_i),
    .byte_off_i (addr_q[1:0]),
    .funct3_i   (f3_q),
    .data_o     (aligned)
  );

  // Store lane placement: narrow data is replicated so every lane carries
  // it and the strobe picks the addressed one.
  always_comb begin
    strb  = 4'b1111;
    wdata = sdata_q;
    case (f3_q[1:0])
      2'b00: begin
        strb  = 4'b0001 << addr_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << addr_q[1:0];
        wdata = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    st_d     = st_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    ldata_d  = ldata_q;
    done     = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    w_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (ld_ok || st_ok)) begin
          f3_d    = f3_in;
          rd_d    = instr_i[11:7];
          st_d    = st_ok;
          addr_d  = addr_i;
          sdata_d = store_data_i;
          state_d = is_misaligned(f3_in, addr_i[1:0]) ? ABORT : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          state_d = RSP;
          cnt_d   = '0;
        end
      end
      RSP: begin
        // A response in the timeout cycle still completes normally.
        if (mem_rsp_valid_i) begin
          if (st_q) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ldata_d = aligned;
            state_d = WB;
          end
        end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(RSP_TIMEOUT))) begin
          bus_err = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        w_en    = (rd_q != 5'd0);
        done    = 1'b1;
        state_d = IDLE;
      end
      ABORT: begin
        misalign = 1'b1;
        done     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and result holding registers; only meaningful while the
  // state says so, so they need no reset.
  always_ff @(posedge clk) begin
    f3_q    <= f3_d;
    rd_q    <= rd_d;
    st_q    <= st_d;
    addr_q  <= addr_d;
    sdata_q <= sdata_d;
    ldata_q <= ldata_d;
  end

  assign in_req = (state_q == REQ);
  assign in_wb  = (state_q == WB);

  assign busy_o          = (state_q != IDLE);
  assign done_o          = done;
  assign misalign_o      = misalign;
  assign bus_err_o       = bus_err;
  assign mem_req_valid_o = in_req;
  assign mem_req_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_req_we_o    = in_req & st_q;
  assign mem_req_wstrb_o = (in_req && st_q) ? strb : 4'b0000;
  assign mem_req_wdata_o = (in_req && st_q) ? wdata : '0;
  assign rf_w_en_o       = w_en;
  assign rf_rd_id_o      = in_wb ? rd_q : 5'd0;
  assign rf_rd_data_o    = in_wb ? ldata_q : '0;

endmodule
